// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 key event decoder: synchronizes the receiver byte strobe,
// folds E0/F0/E1 prefix sequences into single key events, and buffers
// them in a first-word-fall-through FIFO with a valid/ready handshake.
//
// Ports:
//   clk, reset            system clock, synchronous active-high reset
//   ps2_code, ps2_strobe  byte and asynchronous new-byte strobe from receiver
//   evt_code/ext/break    event at the FIFO head
//   evt_valid, evt_ready  head handshake
//   fifo_count            events buffered
//   overflow              sticky, an event was dropped on a full FIFO
//
// Optional build macro TYPEMATIC_FILTER_EN suppresses repeated makes of
// the key currently held down.
module ps2_key_decoder #(
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [7:0]                  ps2_code,
    input  logic                        ps2_strobe,
    output logic [7:0]                  evt_code,
    output logic                        evt_ext,
    output logic                        evt_break,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK,
        S_PAUSE
    } state_t;

    // Strobe synchronizer and byte capture
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;
    logic                   strobe_rise;
    logic [7:0]             byte_q;
    logic                   byte_valid_q;

    // Stages preset to 1 so a strobe held high through reset is not a byte
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
            last_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], ps2_strobe};
            last_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign strobe_rise = sync_q[SYNC_STAGES-1] & ~last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q       <= 8'h00;
            byte_valid_q <= 1'b0;
        end else begin
            byte_valid_q <= strobe_rise;
            if (strobe_rise) begin
                byte_q <= ps2_code;
            end
        end
    end

    // Prefix FSM
    state_t        state_q, state_d;
    logic [2:0]    skip_q;
    logic [TW-1:0] tmo_q;
    logic          tmo_hit;
    logic          ignored;
    logic          emit;
    logic          emit_ext;
    logic          emit_brk;
    logic [7:0]    emit_code;

    // Receiver status/ack bytes that never form key events
    assign ignored = (byte_q == 8'hAA) || (byte_q == 8'hFA) ||
                     (byte_q == 8'hFE) || (byte_q == 8'hEE) ||
                     (byte_q == 8'h00) || (byte_q == 8'hFF);

    assign tmo_hit = (state_q != S_IDLE) && !byte_valid_q &&
                     (tmo_q == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = S_IDLE;
        end else if (byte_valid_q) begin
            unique case (state_q)
                S_IDLE: begin
                    if (byte_q == 8'hE0) begin
                        state_d = S_EXT;
                    end else if (byte_q == 8'hF0) begin
                        state_d = S_BRK;
                    end else if (byte_q == 8'hE1) begin
                        state_d = S_PAUSE;
                    end
                end
                S_EXT: begin
                    if (byte_q == 8'hF0) begin
                        state_d = S_EXT_BRK;
                    end else if (byte_q != 8'hE0) begin
                        state_d = S_IDLE;
                    end
                end
                S_BRK:     state_d = S_IDLE;
                S_EXT_BRK: state_d = S_IDLE;
                S_PAUSE: begin
                    if (skip_q == 3'd1) begin
                        state_d = S_IDLE;
                    end
                end
                default:   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        emit      = 1'b0;
        emit_ext  = 1'b0;
        emit_brk  = 1'b0;
        emit_code = byte_q;
        if (byte_valid_q) begin
            unique case (state_q)
                S_IDLE: begin
                    emit = (byte_q != 8'hE0) && (byte_q != 8'hF0) &&
                           (byte_q != 8'hE1) && !ignored;
                end
                S_EXT: begin
                    emit     = (byte_q != 8'hF0) && (byte_q != 8'hE0);
                    emit_ext = 1'b1;
                end
                S_BRK: begin
                    emit     = 1'b1;
                    emit_brk = 1'b1;
                end
                S_EXT_BRK: begin
                    emit     = 1'b1;
                    emit_ext = 1'b1;
                    emit_brk = 1'b1;
                end
                S_PAUSE: begin
                    // Pause has no break; the whole 8-byte burst is one event
                    emit      = (skip_q == 3'd1);
                    emit_ext  = 1'b1;
                    emit_code = 8'hE1;
                end
                default: emit = 1'b0;
            endcase
        end
    end

    // Remaining bytes of the pause burst after the leading E1
    always_ff @(posedge clk) begin
        if (reset) begin
            skip_q <= 3'd0;
        end else if (byte_valid_q) begin
            if (state_q == S_IDLE && byte_q == 8'hE1) begin
                skip_q <= 3'd7;
            end else if (state_q == S_PAUSE) begin
                skip_q <= skip_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (byte_valid_q || state_q == S_IDLE) begin
            tmo_q <= '0;
        end else if (!tmo_hit) begin
            tmo_q <= tmo_q + TW'(1);
        end
    end

    // Typematic repeat filter
    logic keep;

`ifdef TYPEMATIC_FILTER_EN
    logic       held_q;
    logic [7:0] held_code_q;
    logic       held_ext_q;
    logic       same_key;

    assign same_key = held_q && (held_code_q == emit_code) &&
                      (held_ext_q == emit_ext);
    assign keep     = emit && !(same_key && !emit_brk);

    always_ff @(posedge clk) begin
        if (reset) begin
            held_q      <= 1'b0;
            held_code_q <= 8'h00;
            held_ext_q  <= 1'b0;
        end else if (emit) begin
            if (!emit_brk && !same_key) begin
                held_q      <= 1'b1;
                held_code_q <= emit_code;
                held_ext_q  <= emit_ext;
            end else if (emit_brk && same_key) begin
                held_q <= 1'b0;
            end
        end
    end
`else
    assign keep = emit;
`endif

    // Event staging register feeding the FIFO
    logic       push_q;
    logic [9:0] push_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            push_q      <= 1'b0;
            push_data_q <= '0;
        end else begin
            push_q      <= keep;
            push_data_q <= {emit_ext, emit_brk, emit_code};
        end
    end

    // FWFT event FIFO
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q;
    logic          full;
    logic          empty;
    logic          do_push;
    logic          do_pop;
    logic [9:0]    head;

    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = !empty && evt_ready;
    // A pop on the same cycle frees the slot a full FIFO needs
    assign do_push = push_q && (!full || do_pop);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_d;
            if (push_q && !do_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // Head forced to 0 when empty so outputs are defined out of reset
    assign head       = empty ? 10'h000 : mem_q[rd_ptr_q];
    assign evt_ext    = head[9];
    assign evt_break  = head[8];
    assign evt_code   = head[7:0];
    assign evt_valid  = !empty;
    assign fifo_count = count_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed testbench for ps2_key_decoder.
// Scenario tasks drive scancode bytes and compare against hand-computed events.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ps2_code;
    logic       ps2_strobe;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic       evt_valid;
    logic       evt_ready;
    logic [3:0] fifo_count;
    logic       overflow;

    int checks   = 0;
    int failures = 0;

    logic [9:0] evq[$];

    ps2_key_decoder #(
        .FIFO_DEPTH (8),
        .SYNC_STAGES(2),
        .TIMEOUT_CYC(64)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_code  (ps2_code),
        .ps2_strobe(ps2_strobe),
        .evt_code  (evt_code),
        .evt_ext   (evt_ext),
        .evt_break (evt_break),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .fifo_count(fifo_count),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Record every accepted event ({ext, break, code}) away from the edge
    always @(negedge clk) begin
        if (!reset && evt_valid && evt_ready) begin
            evq.push_back({evt_ext, evt_break, evt_code});
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk);
        #1;
        ps2_code   = b;
        ps2_strobe = 1'b1;
        repeat (6) @(posedge clk);
        #1 ps2_strobe = 1'b0;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        evq.delete();
    endtask

    task automatic test_reset();
        ps2_strobe = 1'b1;
        evt_ready  = 1'b0;
        reset      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({evt_valid, overflow, fifo_count} !== 6'd0) begin
            failures++;
            $display("FAIL reset_status got v=%0b o=%0b c=%0d want 0",
                     evt_valid, overflow, fifo_count);
        end
        checks++;
        if ({evt_ext, evt_break, evt_code} !== 10'h000) begin
            failures++;
            $display("FAIL reset_head got %h want 000",
                     {evt_ext, evt_break, evt_code});
        end
        reset = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checks++;
        if (fifo_count !== 4'd0 || evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_strobe_high got count=%0d want 0", fifo_count);
        end
        ps2_strobe = 1'b0;
        repeat (4) @(posedge clk);
        evq.delete();
    endtask

    task automatic test_make_latency();
        evt_ready = 1'b0;
        @(posedge clk);
        #1;
        ps2_code   = 8'h1C;
        ps2_strobe = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (evt_valid !== 1'b0) begin
            failures++;
            $display("FAIL latency_early got valid=%0b want 0", evt_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (evt_valid !== 1'b1 || fifo_count !== 4'd1) begin
            failures++;
            $display("FAIL latency_valid got v=%0b c=%0d want v=1 c=1",
                     evt_valid, fifo_count);
        end
        checks++;
        if ({evt_ext, evt_break, evt_code} !== 10'h01C) begin
            failures++;
            $display("FAIL make_head got %h want 01c",
                     {evt_ext, evt_break, evt_code});
        end
        ps2_strobe = 1'b0;
        evt_ready  = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (evq.size() != 1 || evq[0] !== 10'h01C || fifo_count !== 4'd0) begin
            failures++;
            $display("FAIL make_pop got n=%0d c=%0d want n=1 c=0",
                     evq.size(), fifo_count);
        end
        evq.delete();
    endtask

    task automatic test_ext_break();
        evt_ready = 1'b1;
        evq.delete();
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        repeat (4) @(posedge clk);
        checks++;
        if (evq.size() != 1 || evq[0] !== 10'h375) begin
            failures++;
            $display("FAIL ext_break got n=%0d ev=%h want n=1 ev=375",
                     evq.size(), evq.size() > 0 ? evq[0] : 10'h0);
        end
        evq.delete();
        send_byte(8'hE0);
        send_byte(8'hE0);
        send_byte(8'h75);
        repeat (4) @(posedge clk);
        checks++;
        if (evq.size() != 1 || evq[0] !== 10'h275) begin
            failures++;
            $display("FAIL ext_make got n=%0d ev=%h want n=1 ev=275",
                     evq.size(), evq.size() > 0 ? evq[0] : 10'h0);
        end
        evq.delete();
    endtask

    task automatic test_pause();
        logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1,
                                8'hF0, 8'h14, 8'hF0, 8'h77};
        evt_ready = 1'b1;
        evq.delete();
        for (int i = 0; i < 8; i++) begin
            send_byte(seq[i]);
        end
        repeat (4) @(posedge clk);
        checks++;
        if (evq.size() != 1 || evq[0] !== 10'h2E1) begin
            failures++;
            $display("FAIL pause got n=%0d ev=%h want n=1 ev=2e1",
                     evq.size(), evq.size() > 0 ? evq[0] : 10'h0);
        end
        evq.delete();
        send_byte(8'hAA);
        send_byte(8'hFA);
        repeat (4) @(posedge clk);
        checks++;
        if (evq.size() != 0) begin
            failures++;
            $display("FAIL ignored_bytes got n=%0d want 0", evq.size());
        end
        evq.delete();
    endtask

    task automatic test_overflow();
        logic [7:0] codes [9] = '{8'h15, 8'h16, 8'h1D, 8'h1E, 8'h24,
                                  8'h25, 8'h26, 8'h2D, 8'h2E};
        evt_ready = 1'b0;
        evq.delete();
        for (int i = 0; i < 9; i++) begin
            send_byte(codes[i]);
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (fifo_count !== 4'd8 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_full got c=%0d o=%0b want c=8 o=1",
                     fifo_count, overflow);
        end
        checks++;
        if (evt_valid !== 1'b1 || evt_code !== 8'h15) begin
            failures++;
            $display("FAIL overflow_hold got v=%0b code=%h want v=1 code=15",
                     evt_valid, evt_code);
        end
        evt_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if (evq.size() != 8) begin
            failures++;
            $display("FAIL drain_count got %0d want 8", evq.size());
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (i >= evq.size() || evq[i] !== {2'b00, codes[i]}) begin
                failures++;
                $display("FAIL drain_order[%0d] got %h want %h", i,
                         i < evq.size() ? evq[i] : 10'h3FF, {2'b00, codes[i]});
            end
        end
        checks++;
        if (fifo_count !== 4'd0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky got c=%0d o=%0b want c=0 o=1",
                     fifo_count, overflow);
        end
        evq.delete();
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b1;
        send_byte(8'hE0);
        do_reset();
        #1;
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_clears_ovf got %0b want 0", overflow);
        end
        send_byte(8'h75);
        repeat (4) @(posedge clk);
        checks++;
        if (evq.size() != 1 || evq[0] !== 10'h075) begin
            failures++;
            $display("FAIL reset_mid got n=%0d ev=%h want n=1 ev=075",
                     evq.size(), evq.size() > 0 ? evq[0] : 10'h0);
        end
        evq.delete();
    endtask

    task automatic test_timeout();
        evt_ready = 1'b1;
        evq.delete();
        send_byte(8'hF0);
        repeat (80) @(posedge clk);
        send_byte(8'h1C);
        repeat (4) @(posedge clk);
        checks++;
        if (evq.size() != 1 || evq[0] !== 10'h01C) begin
            failures++;
            $display("FAIL timeout got n=%0d ev=%h want n=1 ev=01c",
                     evq.size(), evq.size() > 0 ? evq[0] : 10'h0);
        end
        evq.delete();
    endtask

    task automatic test_typematic();
        logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
`ifdef TYPEMATIC_FILTER_EN
        int         n_exp = 3;
        logic [9:0] exp [5] = '{10'h01C, 10'h11C, 10'h01C, 10'h000, 10'h000};
`else
        int         n_exp = 5;
        logic [9:0] exp [5] = '{10'h01C, 10'h01C, 10'h01C, 10'h11C, 10'h01C};
`endif
        evt_ready = 1'b1;
        evq.delete();
        for (int i = 0; i < 6; i++) begin
            send_byte(seq[i]);
        end
        repeat (4) @(posedge clk);
        checks++;
        if (evq.size() != n_exp) begin
            failures++;
            $display("FAIL typematic_count got %0d want %0d", evq.size(), n_exp);
        end
        for (int i = 0; i < n_exp; i++) begin
            checks++;
            if (i >= evq.size() || evq[i] !== exp[i]) begin
                failures++;
                $display("FAIL typematic[%0d] got %h want %h", i,
                         i < evq.size() ? evq[i] : 10'h3FF, exp[i]);
            end
        end
        evq.delete();
    endtask

    initial begin
        reset      = 1'b1;
        ps2_strobe = 1'b1;
        ps2_code   = 8'h00;
        evt_ready  = 1'b0;
        test_reset();
        test_make_latency();
        test_ext_break();
        test_pause();
        test_overflow();
        test_reset_mid();
        test_timeout();
        test_typematic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
